cmp_share_arbiter: RTL and testbench

//  - Shares one 4-bit magnitude comparator between NREQ requesters; round-robin arbitration.
//  - Each requester presents an (a,b) operand pair with a valid/ready handshake.
//  - The block returns the registered gt/lt/eq result tagged with the requester id.
//  - Sits between requesting FSMs and a single magnitude_comparator instance.
//  - One comparison is in flight at a time.

---
 rtl/cmp_share_arbiter_pkg.sv | 16 +
 rtl/cmp_share_arbiter_cmp.sv | 19 +
 rtl/cmp_share_arbiter.sv | 146 ++++++++++++++
 tb/tb_cmp_share_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_share_arbiter_pkg.sv
// Shared definitions for the comparator-sharing arbiter.
//   state_t          : FSM state encoding (IDLE / CMP / RESP)
//   DEF_NREQ/WIDTH/IDW : default instance sizing
package cmp_share_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_IDW   = 2;

endpackage

// File: rtl/cmp_share_arbiter_cmp.sv
// Unsigned magnitude comparator, purely combinational.
// Ports:
//   a, b       : WIDTH-bit unsigned operands
//   gt, lt, eq : a > b, a < b, a == b (exactly one is set)
module magnitude_comparator #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/cmp_share_arbiter.sv
// Shares one magnitude comparator between NREQ requesters with round-robin
// arbitration. One comparison is in flight at a time; the result is
// registered and tagged with the owning requester id.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester handshake, req_ready is a one-hot grant
//   req_a/req_b           : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready   : result handshake
//   rsp_id                : owner of the result
//   rsp_gt/rsp_lt/rsp_eq  : unsigned compare result
//   busy                  : an operation is in progress
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for a request; grant is combinational this cycle
// CMP     | latched operands drive the comparator; result registered
// RESP    | result presented, held until rsp_ready
module cmp_share_arbiter
    import cmp_share_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = DEF_IDW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_gt,
    output logic                  rsp_lt,
    output logic                  rsp_eq,
    output logic                  busy
);

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_eq;

    logic [IDW:0]     pick;
    logic             grant_vld;
    logic [IDW-1:0]   grant_id;

    // Returns {found, index} of the first valid requester at or after ptr,
    // wrapping modulo NREQ. Scanning offsets from high to low lets the
    // smallest offset overwrite the result last, so it wins.
    function automatic logic [IDW:0] rr_pick(
        input logic [NREQ-1:0] valid,
        input logic [IDW-1:0]  ptr
    );
        logic           found;
        logic [IDW-1:0] idx;
        logic [IDW-1:0] j;
        found = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IDW'((int'(ptr) + k) % NREQ);
            if (valid[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
        return {found, idx};
    endfunction

    assign pick      = rr_pick(req_valid, rr_ptr);
    assign grant_vld = pick[IDW] && (state == ST_IDLE);
    assign grant_id  = pick[IDW-1:0];

    // rst_n gates the grant so no requester sees ready while reset is held.
    always_comb begin
        req_ready = '0;
        if (grant_vld && rst_n) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign busy = (state != ST_IDLE);

    magnitude_comparator #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a  (a_q),
        .b  (b_q),
        .gt (cmp_gt),
        .lt (cmp_lt),
        .eq (cmp_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_gt    <= 1'b0;
            rsp_lt    <= 1'b0;
            rsp_eq    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        a_q   <= req_a[grant_id*WIDTH +: WIDTH];
                        b_q   <= req_b[grant_id*WIDTH +: WIDTH];
                        id_q  <= grant_id;
                        state <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    rsp_gt    <= cmp_gt;
                    rsp_lt    <= cmp_lt;
                    rsp_eq    <= cmp_eq;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        // Explicit wrap keeps rr_ptr inside 0..NREQ-1 even
                        // when NREQ is not a power of two.
                        rr_ptr    <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
module tb_cmp_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_gt;
    logic                  rsp_lt;
    logic                  rsp_eq;
    logic                  busy;

    always #5 clk = ~clk;

    cmp_share_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_gt    (rsp_gt),
        .rsp_lt    (rsp_lt),
        .rsp_eq    (rsp_eq),
        .busy      (busy)
    );

    typedef struct {
        int id;
        bit gt;
        bit lt;
        bit eq;
        int cyc;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    // transaction-level reference model
    bit               free      = 1'b1;
    int               ptr       = 0;
    bit               hs_next   = 1'b0;
    bit               acc_next  = 1'b0;
    int               hs_id     = 0;
    int               fly_id    = 0;
    int               fly_cyc   = 0;
    bit               keep_full = 1'b0;
    int               rdy_prob  = 100;
    bit               pend[NREQ];
    logic [WIDTH-1:0] pa[NREQ];
    logic [WIDTH-1:0] pb[NREQ];
    int               grant_log[$];
    int               grant_cyc[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic set_req(input int i, input int a, input int b);
        pend[i] = 1'b1;
        pa[i]   = WIDTH'(a);
        pb[i]   = WIDTH'(b);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    endtask

    // One clock of stimulus: retire what happened at the last edge, drive new
    // inputs, then predict the grant the coming edge will take.
    task automatic drive_cycle(input bit rnd);
        logic [NREQ-1:0] v;
        int g;
        exp_t e;
        @(negedge clk);
        if (hs_next) begin
            pend[hs_id] = 1'b0;
            free        = 1'b0;
            hs_next     = 1'b0;
            if (keep_full) set_req(hs_id, 5, 5);
        end
        if (acc_next) begin
            free     = 1'b1;
            ptr      = (fly_id + 1) % NREQ;
            acc_next = 1'b0;
        end
        if (rnd) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 40)
                    set_req(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                else if (pend[i] && $urandom_range(0, 99) < 5)
                    pend[i] = 1'b0;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]               = pend[i];
            req_a[i*WIDTH +: WIDTH]    = pend[i] ? pa[i] : WIDTH'($urandom);
            req_b[i*WIDTH +: WIDTH]    = pend[i] ? pb[i] : WIDTH'($urandom);
        end
        #2;
        v = req_valid;
        g = -1;
        if (free) begin
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && v[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
        end
        if (g >= 0) begin
            check("grant onehot", int'(req_ready), 1 << g);
            e.id  = g;
            e.gt  = (pa[g] > pb[g]);
            e.lt  = (pa[g] < pb[g]);
            e.eq  = (pa[g] == pb[g]);
            e.cyc = cyc + 2;
            expq.push_back(e);
            hs_next = 1'b1;
            hs_id   = g;
            fly_id  = g;
            fly_cyc = cyc + 2;
            grant_log.push_back(g);
            grant_cyc.push_back(cyc);
        end else begin
            check("no grant", int'(req_ready), 0);
        end
        check("busy", int'(busy), free ? 0 : 1);
        if (!free && cyc >= fly_cyc && rsp_ready) acc_next = 1'b1;
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) drive_cycle(rnd);
    endtask

    // monitor: pops the scoreboard whenever a new response appears
    initial begin
        exp_t cur;
        bit   holding;
        holding = 1'b0;
        cur.id = 0; cur.gt = 0; cur.lt = 0; cur.eq = 0; cur.cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holding = 1'b0;
            end else if (holding && rsp_ready) begin
                check("rsp_valid clears", int'(rsp_valid), 0);
                holding = 1'b0;
            end else if (rsp_valid) begin
                if (!holding) begin
                    if (expq.size() == 0) begin
                        check("unexpected response", expq.size(), 1);
                    end else begin
                        cur = expq.pop_front();
                        check("rsp latency", cyc, cur.cyc);
                        holding = 1'b1;
                    end
                end
                if (holding) begin
                    check("rsp_id", int'(rsp_id), cur.id);
                    check("rsp_gt", int'(rsp_gt), int'(cur.gt));
                    check("rsp_lt", int'(rsp_lt), int'(cur.lt));
                    check("rsp_eq", int'(rsp_eq), int'(cur.eq));
                end
            end else if (holding) begin
                check("rsp_valid held", int'(rsp_valid), 1);
            end
            #1 rsp_ready = ($urandom_range(0, 99) < rdy_prob);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[5];
        int n;
        exp_order = '{0, 1, 2, 3, 0};
        clear_reqs();

        // reset with all requesters valid
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset req_ready", int'(req_ready), 0);
        check("reset rsp_valid", int'(rsp_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset rsp bits", int'({rsp_id, rsp_gt, rsp_lt, rsp_eq}), 0);
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;

        // fairness: all valid, a=b=5, rsp_ready always 1
        rdy_prob  = 100;
        keep_full = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 5, 5);
        n = 0;
        while (grant_log.size() < 5 && n < 40) begin
            drive_cycle(1'b0);
            n++;
        end
        keep_full = 1'b0;
        clear_reqs();
        check("fair grant count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check("fair order", grant_log[i], exp_order[i]);
        for (int i = 1; i < 5 && i < grant_cyc.size(); i++)
            check("op spacing", grant_cyc[i] - grant_cyc[i-1], 3);
        run(6, 1'b0);

        // single request 2: a=9, b=3
        set_req(2, 9, 3);
        drive_cycle(1'b0);
        check("single grant", int'(req_ready), 4);
        run(5, 1'b0);

        // wrap: grant 3 then 4'b1001 must pick 0
        set_req(3, 7, 7);
        drive_cycle(1'b0);
        check("grant 3", grant_log[$], 3);
        run(5, 1'b0);
        set_req(0, 1, 2);
        set_req(3, 2, 1);
        drive_cycle(1'b0);
        check("wrap grant", grant_log[$], 0);
        run(8, 1'b0);

        // backpressure: a=0, b=15 held while rsp_ready=0
        rdy_prob = 0;
        set_req(1, 0, 15);
        drive_cycle(1'b0);
        set_req(0, 3, 3);
        set_req(2, 15, 0);
        run(8, 1'b0);
        rdy_prob = 100;
        run(10, 1'b0);

        // reset while in CMP for requester 1
        clear_reqs();
        set_req(1, 12, 4);
        drive_cycle(1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid reset req_ready", int'(req_ready), 0);
        check("mid reset rsp_valid", int'(rsp_valid), 0);
        check("mid reset busy", int'(busy), 0);
        expq.delete();
        free     = 1'b1;
        ptr      = 0;
        hs_next  = 1'b0;
        acc_next = 1'b0;
        clear_reqs();
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, i, 3 - i);
        drive_cycle(1'b0);
        check("post reset grant", grant_log[$], 0);
        run(15, 1'b0);

        // randomized traffic with random backpressure
        rdy_prob = 70;
        run(1500, 1'b1);

        // drain
        rdy_prob = 100;
        clear_reqs();
        n = 0;
        while (!(free && !hs_next && expq.size() == 0) && n < 40) begin
            drive_cycle(1'b0);
            n++;
        end
        run(3, 1'b0);
        check("scoreboard drained", expq.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
